// File: rtl/iter_muldiv_if.sv
// Request / write-back bundle for the iterative multiply/divide unit.
// The master drives operands and start; the slave (the unit) returns
// status and the register-file write-back fields.
interface iter_muldiv_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        dest_addr;
    logic              busy;
    logic              done;
    logic              reg_write;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic              div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, dest_addr,
        input  busy, done, reg_write, waddr, wdata, hi, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_addr,
        output busy, done, reg_write, waddr, wdata, hi, div_by_zero
    );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One result bit per cycle, DATA_W cycles per operation, plus one DONE
// cycle that pulses the register-file write request.
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, op[1]=1 selects
// two's-complement operation (magnitudes in, sign fix-up on completion).
module iter_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          arst,
    iter_muldiv_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div, r_dbz_pend;
    logic [4:0]          r_dest;
    logic [DATA_W-1:0]   r_opnd, r_hi, r_lo;
    logic                r_busy, r_done, r_dbz;
    logic [4:0]          r_waddr;
    logic [DATA_W-1:0]   r_wdata, r_hi_out;

    logic                w_accept, w_last;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W+1:0]   w_diff;
    logic [DATA_W-1:0]   w_hi_nxt, w_lo_nxt;
    logic [DATA_W-1:0]   w_res_lo, w_res_hi;

    // A request is taken whenever the unit is not iterating (IDLE or DONE).
    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == '0);

`ifdef MULDIV_SIGNED_EN
    logic w_a_neg, w_b_neg;
    logic r_neg_q, r_neg_r;
    logic [2*DATA_W-1:0] w_prod_neg;

    assign w_a_neg    = bus.op[1] & bus.operand_a[DATA_W-1];
    assign w_b_neg    = bus.op[1] & bus.operand_b[DATA_W-1];
    assign w_a_mag    = w_a_neg ? -bus.operand_a : bus.operand_a;
    assign w_b_mag    = w_b_neg ? -bus.operand_b : bus.operand_b;
    assign w_prod_neg = -{w_hi_nxt, w_lo_nxt};

    // Sign flags captured at acceptance alongside the magnitudes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end

    // Sign fix-up of the final iteration. A zero divisor leaves the dividend
    // magnitude as remainder, so the fixed-up remainder is the original a.
    always_comb begin
        w_res_lo = w_lo_nxt;
        w_res_hi = w_hi_nxt;
        if (!r_is_div) begin
            if (r_neg_q) begin
                w_res_lo = w_prod_neg[DATA_W-1:0];
                w_res_hi = w_prod_neg[2*DATA_W-1:DATA_W];
            end
        end else begin
            if (r_neg_q) w_res_lo = -w_lo_nxt;
            if (r_neg_r) w_res_hi = -w_hi_nxt;
        end
        if (r_dbz_pend) w_res_lo = '1;
    end
`else
    logic w_op_unused;
    assign w_op_unused = bus.op[1];
    assign w_a_mag     = bus.operand_a;
    assign w_b_mag     = bus.operand_b;

    // Unsigned only; a zero divisor already leaves remainder = a.
    always_comb begin
        w_res_lo = r_dbz_pend ? '1 : w_lo_nxt;
        w_res_hi = w_hi_nxt;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next-state: RUN for exactly DATA_W cycles, DONE may restart.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = bus.start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One iteration step: shift-add for multiply, trial subtract for divide.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});
        w_diff = {1'b0, r_hi, r_lo[DATA_W-1]} - {2'b00, r_opnd};
        if (r_is_div) begin
            if (!w_diff[DATA_W+1]) begin
                w_hi_nxt = w_diff[DATA_W-1:0];
                w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
            end else begin
                w_hi_nxt = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
                w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_sum[DATA_W:1];
            w_lo_nxt = {w_sum[0], r_lo[DATA_W-1:1]};
        end
    end

    // Iteration down-counter: loaded at acceptance, expires on the last step.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)                   r_cnt <= '0;
        else if (w_accept)          r_cnt <= CNT_W'(DATA_W - 1);
        else if (r_state == RUN)    r_cnt <= r_cnt - 1'b1;
    end

    // Working datapath: capture operands on acceptance, then iterate.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div   <= bus.op[0];
            r_dbz_pend <= bus.op[0] && (bus.operand_b == '0);
            r_dest     <= bus.dest_addr;
            r_opnd     <= bus.op[0] ? w_b_mag : w_a_mag;
            r_lo       <= bus.op[0] ? w_a_mag : w_b_mag;
            r_hi       <= '0;
        end else if (r_state == RUN) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    // Registered outputs; results load only on the RUN->DONE edge and hold.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_hi_out <= '0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            r_done <= (w_state_nxt == DONE);
            if (w_last) begin
                r_waddr  <= r_dest;
                r_wdata  <= w_res_lo;
                r_hi_out <= w_res_hi;
                r_dbz    <= r_dbz_pend;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.reg_write   = r_done;
    assign bus.waddr       = r_waddr;
    assign bus.wdata       = r_wdata;
    assign bus.hi          = r_hi_out;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv (DATA_W=16), expected values hand-computed.
module tb_iter_muldiv;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
    int   done_cnt = 0;
    bit   hold_start = 1'b0;

    iter_muldiv_if #(.DATA_W(16)) bus ();

    iter_muldiv #(.DATA_W(16)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [4:0] dest);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_addr = dest;
        bus.start     = 1'b1;
    endtask

    // Counts negedges until done is seen; lat = -1 if the bound expires.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (!hold_start) bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [4:0] waddr,
                                input logic [15:0] lo, input logic [15:0] hi,
                                input logic dbz);
        chk({tag, "_rw"},    32'(bus.reg_write), 32'h1);
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'(waddr));
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'(lo));
        chk({tag, "_hi"},    32'(bus.hi), 32'(hi));
        chk({tag, "_dbz"},   32'(bus.div_by_zero), 32'(dbz));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] dest,
                          input logic [15:0] lo, input logic [15:0] hi, input logic dbz);
        int lat;
        @(negedge clk);
        start_op(op, a, b, dest);
        wait_done(40, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd17);
        check_result(tag, dest, lo, hi, dbz);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.done), 32'h0);
    endtask

    initial begin
        int lat, snap;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_done",  32'(bus.done), 32'h0);
        chk("rst_rw",    32'(bus.reg_write), 32'h0);
        chk("rst_dbz",   32'(bus.div_by_zero), 32'h0);
        chk("rst_waddr", 32'(bus.waddr), 32'h0);
        chk("rst_wdata", 32'(bus.wdata), 32'h0);
        chk("rst_hi",    32'(bus.hi), 32'h0);
        arst = 1'b0;
        @(negedge clk);

        // Unsigned multiply with busy observed mid-run
        start_op(2'b00, 16'h1234, 16'h0056, 5'd5);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mul1_busy", 32'(bus.busy), 32'h1);
        wait_done(40, lat);
        chk("mul1_lat", 32'(lat + 1), 32'd17);
        chk("mul1_busy_done", 32'(bus.busy), 32'h0);
        check_result("mul1", 5'd5, 16'h1D78, 16'h0006, 1'b0);
        @(negedge clk);
        chk("mul1_pulse", 32'(bus.done), 32'h0);

        // Maximum multiply, start held for a back-to-back second op
        @(negedge clk);
        hold_start = 1'b1;
        start_op(2'b00, 16'hFFFF, 16'hFFFF, 5'd9);
        wait_done(40, lat);
        chk("mulmax_lat", 32'(lat), 32'd17);
        check_result("mulmax", 5'd9, 16'h0001, 16'hFFFE, 1'b0);
        start_op(2'b00, 16'h0003, 16'h0005, 5'd10);
        hold_start = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'h1);
        wait_done(40, lat);
        chk("b2b_lat", 32'(lat + 1), 32'd17);
        check_result("b2b", 5'd10, 16'h000F, 16'h0000, 1'b0);

        // Divide and divide by zero
        run_op("div", 2'b01, 16'h03E8, 16'h0007, 5'd3, 16'h008E, 16'h0006, 1'b0);
        run_op("dbz", 2'b01, 16'h00FF, 16'h0000, 5'd4, 16'hFFFF, 16'h00FF, 1'b1);
        run_op("mul_dbzclr", 2'b00, 16'h0000, 16'h0000, 5'd6, 16'h0000, 16'h0000, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        snap = done_cnt;
        start_op(2'b00, 16'h0010, 16'h0003, 5'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        start_op(2'b01, 16'h0100, 16'h0002, 5'd12);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40, lat);
        chk("busy_lat", 32'(lat + 6), 32'd17);
        check_result("busy", 5'd7, 16'h0030, 16'h0000, 1'b0);
        repeat (20) @(negedge clk);
        chk("busy_ndone", 32'(done_cnt - snap), 32'd1);

        // Reset mid-operation
        start_op(2'b00, 16'h0101, 16'h0202, 5'd8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", 32'(bus.busy), 32'h1);
        #2 arst = 1'b1;
        #1;
        chk("abort_busy",  32'(bus.busy), 32'h0);
        chk("abort_wdata", 32'(bus.wdata), 32'h0);
        chk("abort_hi",    32'(bus.hi), 32'h0);
        chk("abort_waddr", 32'(bus.waddr), 32'h0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        snap = done_cnt;
        repeat (20) @(negedge clk);
        chk("abort_ndone", 32'(done_cnt - snap), 32'd0);
        chk("abort_idle",  32'(bus.busy), 32'h0);

`ifdef MULDIV_SIGNED_EN
        run_op("sdiv",  2'b11, 16'hFFF9, 16'h0002, 5'd1, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("smul",  2'b10, 16'hFFFD, 16'h0004, 5'd2, 16'hFFF4, 16'hFFFF, 1'b0);
        run_op("sovf",  2'b11, 16'h8000, 16'hFFFF, 5'd3, 16'h8000, 16'h0000, 1'b0);
        run_op("sdbz",  2'b11, 16'hFFF9, 16'h0000, 5'd4, 16'hFFFF, 16'hFFF9, 1'b1);
`else
        run_op("nosign_div", 2'b11, 16'hFFF9, 16'h0002, 5'd1, 16'h7FFC, 16'h0001, 1'b0);
        run_op("nosign_mul", 2'b10, 16'hFFFD, 16'h0004, 5'd2, 16'hFFF4, 16'h0003, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
